// File: rtl/microseq_pkg.sv
// microseq_pkg: shared definitions for the accumulator micro-sequencer.
//   OPC_W     opcode field width (fixed at 4)
//   OP_*      opcode encodings; any encoding not listed executes as NOP
//   state_t   control FSM states
//   is_memop  true for opcodes that need a second memory transaction
package microseq_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 4'b0000;
    localparam logic [OPC_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OPC_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OPC_W-1:0] OP_STA = 4'b0011;
    localparam logic [OPC_W-1:0] OP_LDB = 4'b0100;
    localparam logic [OPC_W-1:0] OP_LDA = 4'b1000;
    localparam logic [OPC_W-1:0] OP_JMP = 4'b1001;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'b1011;
    localparam logic [OPC_W-1:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEMOP,
        ST_HALT
    } state_t;

    function automatic logic is_memop(input logic [OPC_W-1:0] op);
        return (op == OP_LDA) || (op == OP_LDB) || (op == OP_STA);
    endfunction

endpackage

// File: rtl/microseq_alu.sv
// microseq_alu: combinational adder/subtractor for the accumulator datapath.
//   i_a, i_b   operands (DATA_W)
//   i_op       current opcode; OP_SUB selects subtraction, anything else adds
//   o_result   result modulo 2^DATA_W
//   o_carry    carry-out for ADD, borrow (i_a < i_b) for SUB
//   o_zero     result equals zero
module microseq_alu
    import microseq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [OPC_W-1:0]  i_op,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry,
    output logic              o_zero
);

    logic [DATA_W:0] w_sum;

    // One extra bit: it holds the carry on add and goes high on borrow
    // when the zero-extended difference wraps negative.
    always_comb begin
        if (i_op == OP_SUB) begin
            w_sum = {1'b0, i_a} - {1'b0, i_b};
        end else begin
            w_sum = {1'b0, i_a} + {1'b0, i_b};
        end
    end

    assign o_result = w_sum[DATA_W-1:0];
    assign o_carry  = w_sum[DATA_W];
    assign o_zero   = (w_sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/microseq_core.sv
// microseq_core: multi-cycle accumulator micro-sequencer with a single
// request/acknowledge memory port shared by instruction fetch and data access.
//   clk, reset            clock; synchronous active-high reset
//   mem_req/we/addr/wdata memory request, held until mem_ack
//   mem_ack, mem_rdata    completion strobe and read data
//   retire                one-cycle pulse per completed instruction
//   halted                core has executed HLT
//   pc_out, acc_out       architectural PC and accumulator
//   flag_z, flag_c        zero flag and carry/borrow flag
module microseq_core
    import microseq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              retire,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] acc_out,
    output logic              flag_z,
    output logic              flag_c
);

    if (DATA_W < OPC_W + ADDR_W) begin : g_bad_params
        $error("microseq_core: DATA_W must be at least OPC_W + ADDR_W");
    end

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_acc;
    logic              r_z;
    logic              r_c;
    logic              r_retire;

    logic [OPC_W-1:0]  w_opc;
    logic [ADDR_W-1:0] w_opnd;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_c;
    logic              w_alu_z;

    assign w_opc  = r_ir[DATA_W-1 -: OPC_W];
    assign w_opnd = r_ir[ADDR_W-1:0];

    microseq_alu #(.DATA_W(DATA_W)) u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (w_opc),
        .o_result (w_alu_res),
        .o_carry  (w_alu_c),
        .o_zero   (w_alu_z)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Bus outputs depend only on state and registers, so they cannot change
    // while a request waits for its acknowledge.
    always_comb begin
        w_next   = r_state;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = r_pc;
        case (r_state)
            ST_IDLE:   w_next = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) w_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_memop(w_opc))       w_next = ST_MEMOP;
                else if (w_opc == OP_HLT)  w_next = ST_HALT;
                else                       w_next = ST_FETCH;
            end
            ST_MEMOP: begin
                mem_req  = 1'b1;
                mem_addr = w_opnd;
                mem_we   = (w_opc == OP_STA);
                if (mem_ack) w_next = ST_FETCH;
            end
            ST_HALT:   w_next = ST_HALT;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_retire <= 1'b0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (mem_ack) begin
                        r_ir <= mem_rdata;
                        r_pc <= r_pc + ADDR_W'(1);
                    end
                end
                ST_DECODE: begin
                    case (w_opc)
                        OP_ADD, OP_SUB: begin
                            r_acc    <= w_alu_res;
                            r_c      <= w_alu_c;
                            r_z      <= w_alu_z;
                            r_retire <= 1'b1;
                        end
                        OP_JMP: begin
                            r_pc     <= w_opnd;
                            r_retire <= 1'b1;
                        end
                        OP_JZ: begin
                            if (r_z) r_pc <= w_opnd;
                            r_retire <= 1'b1;
                        end
                        // Memory ops retire from MEMOP; HLT never retires.
                        OP_LDA, OP_LDB, OP_STA, OP_HLT: ;
                        default: r_retire <= 1'b1;
                    endcase
                end
                ST_MEMOP: begin
                    if (mem_ack) begin
                        if (w_opc == OP_LDA) r_a <= mem_rdata;
                        if (w_opc == OP_LDB) r_b <= mem_rdata;
                        r_retire <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_wdata = r_acc;
    assign retire    = r_retire;
    assign halted    = (r_state == ST_HALT);
    assign pc_out    = r_pc;
    assign acc_out   = r_acc;
    assign flag_z    = r_z;
    assign flag_c    = r_c;

endmodule

// File: tb/tb_microseq_core.sv
// tb_microseq_core: instruction-level reference model of the sequencer that
// predicts every bus transaction, retire pulse and halt, checked each cycle
// against an 8/4 core with randomized acknowledge latency; a 16/8 core runs
// a relocated program that wraps the PC.
module tb_microseq_core;

    localparam int DW = 8;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 8/4 core under random and directed stimulus
    logic          reset = 1'b1;
    logic          mem_req, mem_we, mem_ack = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          retire, halted, flag_z, flag_c;
    logic [AW-1:0] pc_out;
    logic [DW-1:0] acc_out;
    logic [DW-1:0] bmem [16];

    assign mem_rdata = bmem[mem_addr];

    microseq_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .retire(retire), .halted(halted),
        .pc_out(pc_out), .acc_out(acc_out), .flag_z(flag_z), .flag_c(flag_c)
    );

    always @(posedge clk)
        if (!reset && mem_req && mem_ack && mem_we) bmem[mem_addr] <= mem_wdata;

    // ---------------- 16/8 core, zero-wait memory
    logic        reset16 = 1'b1;
    logic        req16, we16, ack16, retire16, halted16, z16, c16;
    logic [7:0]  addr16, pc16;
    logic [15:0] wdata16, rdata16, acc16;
    logic [15:0] mem16 [256];
    int          ret16 = 0;

    assign rdata16 = mem16[addr16];
    assign ack16   = req16;

    microseq_core #(.DATA_W(16), .ADDR_W(8)) dut16 (
        .clk(clk), .reset(reset16), .mem_req(req16), .mem_we(we16),
        .mem_addr(addr16), .mem_wdata(wdata16), .mem_ack(ack16),
        .mem_rdata(rdata16), .retire(retire16), .halted(halted16),
        .pc_out(pc16), .acc_out(acc16), .flag_z(z16), .flag_c(c16)
    );

    always @(posedge clk)
        if (!reset16 && req16 && ack16 && we16) mem16[addr16] <= wdata16;
    always @(negedge clk) if (retire16) ret16++;

    // ---------------- bookkeeping
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- acknowledge generator
    // ack_mode: 0 random waits 0..3, 1 zero-wait, 2 never ack, 3 ack held high
    int ack_mode  = 1;
    int sta_wait  = -1;
    int wait_left = 0;
    bit in_req    = 0;
    bit txn_done  = 0;

    always @(posedge clk) begin
        #1;
        if (txn_done || !mem_req) in_req = 0;
        txn_done = 0;
        if (!mem_req) begin
            mem_ack = (ack_mode == 3) ? 1'b1 : 1'($urandom_range(0, 1));
        end else begin
            if (!in_req) begin
                in_req = 1;
                if (mem_we && sta_wait >= 0) wait_left = sta_wait;
                else if (ack_mode == 0)      wait_left = $urandom_range(0, 3);
                else                         wait_left = 0;
            end
            if (ack_mode == 2)       mem_ack = 1'b0;
            else if (ack_mode == 3)  mem_ack = 1'b1;
            else if (wait_left == 0) mem_ack = 1'b1;
            else begin
                mem_ack = 1'b0;
                wait_left--;
            end
        end
    end

    // ---------------- reference model and per-cycle compare
    logic [DW-1:0] m_mem [16];
    logic [AW-1:0] m_pc = '0;
    logic [DW-1:0] m_acc = '0, m_a = '0, m_b = '0;
    logic          m_z = 1'b0, m_c = 1'b0, m_halt = 1'b0;
    logic          exp_fetch = 1'b1, exp_we = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wd = '0;
    logic [3:0]    m_opc = '0;
    logic [AW-1:0] m_opnd = '0;
    logic [DW-1:0] ins;
    logic [AW-1:0] p_addr = '0;
    logic          p_we = 1'b0;
    logic [DW-1:0] p_wd = '0;
    logic          exp_h;
    int  cyc = 0, retire_due = -1, decode_cyc = -1, halt_due = -1;
    bit  prev_wait = 0, rst_seen = 1, chk_en = 0;
    int  n_ret = 0, we_cycles = 0;

    always @(negedge clk) begin
        cyc++;
        if (retire) n_ret++;
        if (mem_req && mem_we && mem_addr == 4'd12 && mem_wdata == 8'h5A) we_cycles++;
        if (mem_req && mem_ack && !reset) txn_done = 1;
        if (chk_en) begin
            if (rst_seen) begin
                chk("post_reset_outputs",
                    32'({mem_req, retire, halted, pc_out, acc_out, flag_z, flag_c}), 32'd0);
            end else begin
                chk("retire", 32'(retire), 32'(cyc == retire_due));
                if (cyc == retire_due)
                    chk("retire_state", 32'({pc_out, acc_out, flag_z, flag_c}),
                        32'({m_pc, m_acc, m_z, m_c}));
                exp_h = m_halt && (cyc >= halt_due);
                chk("halted", 32'(halted), 32'(exp_h));
                if (exp_h) chk("halt_no_req", 32'(mem_req), 32'd0);
                if (cyc == halt_due)
                    chk("halt_state", 32'({pc_out, acc_out, flag_z, flag_c}),
                        32'({m_pc, m_acc, m_z, m_c}));
                if (cyc == decode_cyc) chk("decode_no_req", 32'(mem_req), 32'd0);
                if (prev_wait && mem_req)
                    chk("bus_stable", 32'({mem_addr, mem_we, mem_wdata}),
                        32'({p_addr, p_we, p_wd}));
                if (mem_req && mem_ack && !reset) begin
                    chk("txn", 32'({mem_addr, mem_we, mem_we ? mem_wdata : 8'h00}),
                        32'({exp_addr, exp_we, exp_we ? exp_wd : 8'h00}));
                    if (exp_fetch) begin
                        ins        = m_mem[m_pc];
                        m_pc       = m_pc + 4'd1;
                        m_opc      = ins[7:4];
                        m_opnd     = ins[3:0];
                        decode_cyc = cyc + 1;
                        case (m_opc)
                            4'b0010: begin
                                {m_c, m_acc} = {1'b0, m_a} + {1'b0, m_b};
                                m_z = (m_acc == 8'd0);
                                retire_due = cyc + 2;
                            end
                            4'b0001: begin
                                m_c   = (m_a < m_b);
                                m_acc = m_a - m_b;
                                m_z   = (m_acc == 8'd0);
                                retire_due = cyc + 2;
                            end
                            4'b1001: begin m_pc = m_opnd; retire_due = cyc + 2; end
                            4'b1011: begin
                                if (m_z) m_pc = m_opnd;
                                retire_due = cyc + 2;
                            end
                            4'b1000, 4'b0100, 4'b0011: begin
                                exp_fetch = 1'b0;
                                exp_addr  = m_opnd;
                                exp_we    = (m_opc == 4'b0011);
                                exp_wd    = m_acc;
                            end
                            4'b1111: begin m_halt = 1'b1; halt_due = cyc + 2; end
                            default: retire_due = cyc + 2;
                        endcase
                    end else begin
                        if (m_opc == 4'b1000) m_a = m_mem[m_opnd];
                        if (m_opc == 4'b0100) m_b = m_mem[m_opnd];
                        if (m_opc == 4'b0011) m_mem[m_opnd] = m_acc;
                        retire_due = cyc + 1;
                        exp_fetch  = 1'b1;
                    end
                    if (exp_fetch) begin
                        exp_addr = m_pc;
                        exp_we   = 1'b0;
                        exp_wd   = '0;
                    end
                end
            end
            if (reset) begin
                m_pc = '0; m_acc = '0; m_a = '0; m_b = '0;
                m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
                exp_fetch = 1'b1; exp_addr = '0; exp_we = 1'b0; exp_wd = '0;
                retire_due = -1; decode_cyc = -1; halt_due = -1;
            end
        end
        prev_wait = mem_req && !mem_ack;
        p_addr = mem_addr; p_we = mem_we; p_wd = mem_wdata;
        rst_seen = reset;
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        bmem[a]  = d;
        m_mem[a] = d;
    endtask

    task automatic new_prog();
        reset = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 16; i++) wr(i, 8'h00);
        n_ret = 0;
    endtask

    task automatic go();
        reset = 1'b0;
    endtask

    task automatic run_halt(input int maxc);
        int t = 0;
        while (!halted && t < maxc) begin
            @(negedge clk);
            t++;
        end
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic wait_ret(input int k, input int maxc, input string nm, input logic [AW-1:0] pc_exp);
        int t = 0, seen = 0;
        while (seen < k && t < maxc) begin
            @(negedge clk);
            t++;
            if (retire) seen++;
        end
        chk({nm, "_reached"}, 32'(seen), 32'(k));
        chk({nm, "_pc"}, 32'(pc_out), 32'(pc_exp));
    endtask

    task automatic poll_fetch(input logic [AW-1:0] a, input int maxc, input string nm);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(mem_req && !mem_we && mem_addr == a) && t < maxc);
        chk(nm, 32'({mem_req, mem_addr}), 32'({1'b1, a}));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        // 16/8 core: jump to 250, run the load/add program, HLT fetched at 255.
        for (int i = 0; i < 256; i++) mem16[i] = 16'h0000;
        mem16[0]   = 16'h90FA;
        mem16[250] = 16'h8006;
        mem16[251] = 16'h4007;
        mem16[252] = 16'h2000;
        mem16[255] = 16'hF000;
        mem16[6]   = 16'd14;
        mem16[7]   = 16'd12;
        tick(); tick();
        ret16 = 0;
        reset16 = 1'b0;
        t = 0;
        while (!halted16 && t < 100) begin @(negedge clk); t++; end
        chk("w16_halted", 32'(halted16), 32'd1);
        chk("w16_acc", 32'(acc16), 32'd26);
        chk("w16_pc_wrap", 32'(pc16), 32'd0);
        chk("w16_flags", 32'({z16, c16}), 32'd0);
        chk("w16_retires", 32'(ret16), 32'd6);

        // 8/4 core
        new_prog();
        chk_en = 1;
        wr(0, 8'h86); wr(1, 8'h47); wr(2, 8'h20); wr(3, 8'hF0);
        wr(6, 8'd14); wr(7, 8'd12);
        go();
        run_halt(80);
        chk("p39_acc", 32'(acc_out), 32'd26);
        chk("p39_flags", 32'({flag_z, flag_c}), 32'd0);
        chk("p39_pc", 32'(pc_out), 32'd4);
        chk("p39_retires", 32'(n_ret), 32'd3);

        new_prog();
        wr(0, 8'h88); wr(1, 8'h49); wr(2, 8'h20); wr(3, 8'hF0);
        wr(8, 8'd200); wr(9, 8'd100);
        go();
        run_halt(80);
        chk("add_ovf", 32'({acc_out, flag_z, flag_c}), 32'({8'd44, 1'b0, 1'b1}));

        new_prog();
        wr(0, 8'h8A); wr(1, 8'h4A); wr(2, 8'h10); wr(3, 8'hF0); wr(10, 8'd5);
        go();
        run_halt(80);
        chk("sub_zero", 32'({acc_out, flag_z, flag_c}), 32'({8'd0, 1'b1, 1'b0}));

        new_prog();
        wr(0, 8'h8D); wr(1, 8'h4D); wr(2, 8'h10); wr(3, 8'hB9); wr(9, 8'hF0);
        wr(13, 8'd5);
        go();
        wait_ret(4, 80, "jz_taken", 4'd9);
        run_halt(40);
        chk("jz_taken_end", 32'(pc_out), 32'd10);

        new_prog();
        wr(0, 8'h8D); wr(1, 8'h4E); wr(2, 8'h10); wr(3, 8'hB9); wr(4, 8'hF0);
        wr(13, 8'd5); wr(14, 8'd3);
        go();
        wait_ret(4, 80, "jz_not_taken", 4'd4);
        run_halt(40);
        chk("jz_not_taken_end", 32'({pc_out, acc_out}), 32'({4'd5, 8'd2}));

        new_prog();
        wr(0, 8'h9F); wr(15, 8'h90);
        go();
        wait_ret(1, 40, "jmp15", 4'd15);
        wait_ret(1, 40, "jmp0_from15", 4'd0);

        new_prog();
        wr(0, 8'h9F); wr(15, 8'h00);
        go();
        wait_ret(2, 40, "pc_wrap", 4'd0);

        new_prog();
        wr(0, 8'h8A); wr(1, 8'h4B); wr(2, 8'h20); wr(3, 8'h3C); wr(4, 8'hF0);
        wr(10, 8'h5A);
        sta_wait  = 3;
        we_cycles = 0;
        go();
        run_halt(80);
        sta_wait = -1;
        chk("sta_held_cycles", 32'(we_cycles), 32'd4);
        chk("sta_mem", 32'(bmem[12]), 32'h5A);
        chk("sta_retires", 32'(n_ret), 32'd4);

        // Reset while the fetch of address 2 waits, ack arriving with reset.
        new_prog();
        wr(2, 8'h85); wr(5, 8'h77);
        go();
        poll_fetch(4'd1, 30, "rf_fetch1");
        ack_mode = 2;
        poll_fetch(4'd2, 30, "rf_fetch2");
        ack_mode = 3;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ack_mode = 1;
        @(negedge clk);
        chk("rf_req_dropped", 32'({mem_req, pc_out}), 32'd0);
        poll_fetch(4'd0, 30, "rf_refetch0");
        chk("rf_pc_kept", 32'(pc_out), 32'd0);

        // Random programs with random waits and occasional mid-run resets.
        for (int r = 0; r < 40; r++) begin
            logic [3:0] opc;
            int pick;
            new_prog();
            for (int i = 0; i < 16; i++) begin
                pick = $urandom_range(0, 9);
                case (pick)
                    0: opc = 4'b0000; 1: opc = 4'b0001; 2: opc = 4'b0010;
                    3: opc = 4'b0011; 4: opc = 4'b0100; 5: opc = 4'b1000;
                    6: opc = 4'b1001; 7: opc = 4'b1011; 8: opc = 4'b1111;
                    default: opc = 4'($urandom_range(0, 15));
                endcase
                if (i >= 8 && $urandom_range(0, 1) == 1) wr(i, 8'($urandom_range(0, 255)));
                else wr(i, {opc, 4'($urandom_range(0, 15))});
            end
            ack_mode = 0;
            go();
            t = 0;
            while (!halted && t < 120) begin
                tick();
                t++;
                if (t == 40 && $urandom_range(0, 3) == 0) begin
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                end
            end
        end
        ack_mode = 1;
        reset = 1'b1;
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
